// File: rtl/stage_sequencer_pkg.sv
// Shared CPU package: sequencer state codes, opcode/funct constants and decode helpers.
// Reused by the multicycle controller and the executer.
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_TRAP = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [2:0] OP_IMM_HI = 3'b001;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef struct packed {
    logic pc_write;
    logic ir_write;
    logic reg_write;
    logic jal;
    logic mem_to_reg;
    logic reg_dst;
    logic mem_req;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic jump;
  } ctrl_t;

  function automatic logic is_imm(input logic [5:0] op);
    return op[5:3] == OP_IMM_HI;
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || is_branch(op) ||
           (op == OP_J) || (op == OP_JAL) || is_imm(op);
  endfunction

endpackage

// File: rtl/stage_sequencer_mem_wait_timer.sv
// MEM-state wait counter: counts cycles spent waiting for mem_ready and flags the timeout cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_done,
  output logic o_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Timeout fires on the TIMEOUT-th MEM cycle; a late mem_ready on that same cycle still wins.
  assign o_timeout = i_active & ~i_done & (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_cnt <= '0;
    else if (!i_active || i_done || o_timeout) r_cnt <= '0;
    else                                      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle control sequencer: IF/ID/EX/MEM/WB walk with trap on bad opcode or MEM timeout.
// Controls are decoded from the current state, so an async reset drops them immediately.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        pc_write,
  output logic        ir_write,
  output logic        RegWrite,
  output logic        Jal,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ALUSrc,
  output logic        Branch,
  output logic        Jump,
  output logic [2:0]  state,
  output logic        retire,
  output logic [31:0] retired_cnt,
  output logic        trap
);

  state_e      r_state;
  logic [5:0]  r_op;
  logic [5:0]  r_funct;
  logic [31:0] r_retired_cnt;

  ctrl_t       w_ctl;
  logic        w_retire;
  logic        w_timeout;
  logic [5:0]  w_id_op;
  logic        w_id_jmp;
  logic        w_unused;

  assign w_id_op  = instruction[31:26];
  assign w_id_jmp = (w_id_op == OP_J) || ((w_id_op == OP_RTYPE) && (instruction[5:0] == FN_JR));
  assign w_unused = ^{instruction[25:6], r_funct};

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_mem_wait_timer (
    .clk       (clk),
    .rst_n     (rst),
    .i_active  (r_state == ST_MEM),
    .i_done    (mem_ready),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_ctl    = '0;
    w_retire = 1'b0;
    if (rst) begin
      case (r_state)
        ST_IF: begin
          w_ctl.pc_write = 1'b1;
          w_ctl.ir_write = 1'b1;
        end
        ST_ID: begin
          // j/jr finish here, decoding straight off the IR before the latch lands.
          if (w_id_jmp) begin
            w_ctl.jump     = 1'b1;
            w_ctl.pc_write = 1'b1;
            w_retire       = 1'b1;
          end
        end
        ST_EX: begin
          w_ctl.alu_src = (r_op == OP_LW) || (r_op == OP_SW) || is_imm(r_op);
          if (is_branch(r_op)) begin
            w_ctl.branch   = 1'b1;
            w_ctl.pc_write = (r_op == OP_BEQ) ? zero : ~zero;
            w_retire       = 1'b1;
          end
        end
        ST_MEM: begin
          w_ctl.mem_req   = 1'b1;
          w_ctl.mem_read  = (r_op == OP_LW);
          w_ctl.mem_write = (r_op == OP_SW);
          w_retire        = mem_ready && (r_op == OP_SW);
        end
        ST_WB: begin
          w_ctl.reg_write  = 1'b1;
          w_ctl.mem_to_reg = (r_op == OP_LW);
          w_ctl.reg_dst    = (r_op == OP_RTYPE);
          if (r_op == OP_JAL) begin
            w_ctl.jal      = 1'b1;
            w_ctl.pc_write = 1'b1;
            w_ctl.jump     = 1'b1;
          end
          w_retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IF;
      r_op    <= '0;
      r_funct <= '0;
    end else begin
      case (r_state)
        ST_IF: r_state <= ST_ID;
        ST_ID: begin
          r_op    <= w_id_op;
          r_funct <= instruction[5:0];
          if (!op_supported(w_id_op)) r_state <= ST_TRAP;
          else if (w_id_jmp)          r_state <= ST_IF;
          else if (w_id_op == OP_JAL) r_state <= ST_WB;
          else                        r_state <= ST_EX;
        end
        ST_EX: begin
          if (is_branch(r_op))                        r_state <= ST_IF;
          else if ((r_op == OP_LW) || (r_op == OP_SW)) r_state <= ST_MEM;
          else                                        r_state <= ST_WB;
        end
        ST_MEM: begin
          if (mem_ready)      r_state <= (r_op == OP_SW) ? ST_IF : ST_WB;
          else if (w_timeout) r_state <= ST_TRAP;
        end
        ST_WB:   r_state <= ST_IF;
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_retired_cnt <= '0;
    else if (w_retire) r_retired_cnt <= r_retired_cnt + 32'd1;
  end

  assign pc_write    = w_ctl.pc_write;
  assign ir_write    = w_ctl.ir_write;
  assign RegWrite    = w_ctl.reg_write;
  assign Jal         = w_ctl.jal;
  assign MemtoReg    = w_ctl.mem_to_reg;
  assign RegDst      = w_ctl.reg_dst;
  assign mem_req     = w_ctl.mem_req;
  assign mem_read    = w_ctl.mem_read;
  assign mem_write   = w_ctl.mem_write;
  assign ALUSrc      = w_ctl.alu_src;
  assign Branch      = w_ctl.branch;
  assign Jump        = w_ctl.jump;
  assign state       = r_state;
  assign retire      = w_retire;
  assign retired_cnt = r_retired_cnt;
  assign trap        = (r_state == ST_TRAP) && rst;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed vector table, random instruction stream, reset corner cases.
module tb_stage_sequencer;
  localparam int MEM_TO = 15;
  localparam int C_R = 0, C_JR = 1, C_J = 2, C_JAL = 3, C_BEQ = 4, C_BNE = 5,
                 C_LW = 6, C_SW = 7, C_IMM = 8, C_BAD = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        mem_ready, zero;
  logic        pc_write, ir_write, RegWrite, Jal, MemtoReg, RegDst;
  logic        mem_req, mem_read, mem_write, ALUSrc, Branch, Jump;
  logic [2:0]  state;
  logic        retire, trap;
  logic [31:0] retired_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  stage_sequencer #(.MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .RegWrite(RegWrite), .Jal(Jal),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .mem_req(mem_req), .mem_read(mem_read),
    .mem_write(mem_write), .ALUSrc(ALUSrc), .Branch(Branch), .Jump(Jump),
    .state(state), .retire(retire), .retired_cnt(retired_cnt), .trap(trap)
  );

  wire [11:0] ctl = {pc_write, ir_write, RegWrite, Jal, MemtoReg, RegDst,
                     mem_req, mem_read, mem_write, ALUSrc, Branch, Jump};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'd0)             return (ins[5:0] == 6'b001000) ? C_JR : C_R;
    if (op == 6'd2)             return C_J;
    if (op == 6'd3)             return C_JAL;
    if (op == 6'd4)             return C_BEQ;
    if (op == 6'd5)             return C_BNE;
    if (op == 6'd35)            return C_LW;
    if (op == 6'd43)            return C_SW;
    if (op[5:3] == 3'b001)      return C_IMM;
    return C_BAD;
  endfunction

  // Expected control word {pcw,irw,rw,jal,m2r,rdst,mreq,mrd,mwr,alus,br,jmp} per stage.
  function automatic logic [11:0] exp_ctl(input int cls, input int st, input bit z);
    logic [11:0] e;
    e = '0;
    case (st)
      0: begin e[11] = 1'b1; e[10] = 1'b1; end
      1: if (cls == C_J || cls == C_JR) begin e[11] = 1'b1; e[0] = 1'b1; end
      2: begin
        e[2] = (cls == C_LW || cls == C_SW || cls == C_IMM);
        if (cls == C_BEQ) begin e[1] = 1'b1; e[11] = z;  end
        if (cls == C_BNE) begin e[1] = 1'b1; e[11] = !z; end
      end
      3: begin e[5] = 1'b1; e[4] = (cls == C_LW); e[3] = (cls == C_SW); end
      4: begin
        e[9] = 1'b1; e[7] = (cls == C_LW); e[6] = (cls == C_R);
        if (cls == C_JAL) begin e[8] = 1'b1; e[11] = 1'b1; e[0] = 1'b1; end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Called at a negedge; leaves reset released at the following negedge with DUT in IF.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_cnt", retired_cnt, 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    m_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // rdy_at: MEM cycle (1-based) on which mem_ready rises; 0 or >MEM_TO means never in time.
  task automatic run(input string tag, input logic [31:0] ins, input bit z, input int rdy_at,
                     input bit noise, output int ret_cyc);
    int  cls, memidx, nmem;
    int  q[$];
    bit  trapping, exp_ret;
    cls = cls_of(ins);
    ret_cyc = 0; trapping = 0; memidx = 0;
    q = {0, 1};
    case (cls)
      C_BAD:        trapping = 1;
      C_JAL:        q.push_back(4);
      C_BEQ, C_BNE: q.push_back(2);
      C_R, C_IMM:   begin q.push_back(2); q.push_back(4); end
      C_LW, C_SW: begin
        q.push_back(2);
        trapping = !(rdy_at >= 1 && rdy_at <= MEM_TO);
        nmem = trapping ? MEM_TO : rdy_at;
        repeat (nmem) q.push_back(3);
        if (cls == C_LW && !trapping) q.push_back(4);
      end
      default: ;
    endcase
    foreach (q[i]) begin
      if (q[i] == 3) memidx++;
      instruction = ins;
      zero        = z;
      mem_ready   = (q[i] == 3) ? (memidx == rdy_at) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      #1;
      exp_ret = (i == q.size() - 1) && !trapping;
      chk($sformatf("%s c%0d state", tag, i + 1), 32'(state), 32'(q[i]));
      chk($sformatf("%s c%0d ctl", tag, i + 1), 32'(ctl), 32'(exp_ctl(cls, q[i], z)));
      chk($sformatf("%s c%0d retire", tag, i + 1), 32'(retire), 32'(exp_ret));
      chk($sformatf("%s c%0d trap", tag, i + 1), 32'(trap), 32'd0);
      if (retire && ret_cyc == 0) ret_cyc = i + 1;
      if (exp_ret) m_cnt = m_cnt + 32'd1;
      @(negedge clk);
    end
    if (trapping) begin
      for (int k = 0; k < 3; k++) begin
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk($sformatf("%s trap%0d state", tag, k), 32'(state), 32'd5);
        chk($sformatf("%s trap%0d trap", tag, k), 32'(trap), 32'd1);
        chk($sformatf("%s trap%0d ctl", tag, k), 32'(ctl), 32'd0);
        chk($sformatf("%s trap%0d retire", tag, k), 32'(retire), 32'd0);
        @(negedge clk);
      end
      chk($sformatf("%s cnt", tag), retired_cnt, m_cnt);
      mem_ready = 1'b0;
      do_reset();
    end else begin
      chk($sformatf("%s cnt", tag), retired_cnt, m_cnt);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    bit          z;
    int          rdy;
    int          lat;   // cycle of retire; 0 = expected trap, no retire
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[16];
    int          rc;
    logic [31:0] ins;
    logic [5:0]  op, fn;
    int          k, rdy;

    vt[0]  = '{32'h012A4020, 1'b0, 0,  4};   // add
    vt[1]  = '{32'h8D280004, 1'b0, 3,  7};   // lw, ready on 3rd MEM cycle
    vt[2]  = '{32'h11090003, 1'b1, 0,  3};   // beq taken
    vt[3]  = '{32'h11090003, 1'b0, 0,  3};   // beq not taken
    vt[4]  = '{32'h0C000010, 1'b0, 0,  3};   // jal
    vt[5]  = '{32'hAD280004, 1'b0, 0,  0};   // sw, never ready -> trap
    vt[6]  = '{32'h08000010, 1'b0, 0,  2};   // j
    vt[7]  = '{32'h03E00008, 1'b0, 0,  2};   // jr
    vt[8]  = '{32'h15090003, 1'b0, 0,  3};   // bne taken
    vt[9]  = '{32'h21290001, 1'b1, 0,  4};   // addi
    vt[10] = '{32'h8D280004, 1'b0, 1,  5};   // lw, immediate ready
    vt[11] = '{32'hAD280004, 1'b0, 1,  4};   // sw, immediate ready
    vt[12] = '{32'hAD280004, 1'b0, 15, 18};  // sw, ready on last allowed cycle
    vt[13] = '{32'h8D280004, 1'b0, 16, 0};   // lw, ready one cycle too late
    vt[14] = '{32'hFC000000, 1'b0, 0,  0};   // unsupported opcode
    vt[15] = '{32'h8D280004, 1'b1, 15, 19};

    rst = 1'b0; instruction = '0; mem_ready = 1'b0; zero = 1'b0; m_cnt = '0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      run($sformatf("vec%0d", i), vt[i].ins, vt[i].z, vt[i].rdy, 1'b0, rc);
      chk($sformatf("vec%0d latency", i), 32'(rc), 32'(vt[i].lat));
    end

    // Reset during MEM: mem_req must drop without waiting for a clock, and nothing retires.
    do_reset();
    instruction = 32'h8D280004; mem_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("midmem state", 32'(state), 32'd3);
    chk("midmem mem_req", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async mem_req", 32'(mem_req), 32'd0);
    chk("async state", 32'(state), 32'd0);
    chk("async retire", 32'(retire), 32'd0);
    chk("async cnt", retired_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post-rst ctl", 32'(ctl), 32'hC00);
    @(negedge clk);
    do_reset();

    // Counter wrap: preset to all-ones, then one j retires.
    force dut.r_retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired_cnt;
    m_cnt = 32'hFFFF_FFFF;
    run("wrap_j", 32'h08000010, 1'b0, 0, 1'b0, rc);
    chk("wrap cnt", retired_cnt, 32'd0);

    // Random instruction stream with noise on mem_ready outside MEM.
    for (int n = 0; n < 40; n++) begin
      k   = $urandom_range(0, 9);
      fn  = 6'($urandom_range(0, 63));
      rdy = $urandom_range(0, 17);
      case (k)
        C_R:     begin op = 6'd0; if (fn == 6'd8) fn = 6'd32; end
        C_JR:    begin op = 6'd0; fn = 6'd8; end
        C_J:     op = 6'd2;
        C_JAL:   op = 6'd3;
        C_BEQ:   op = 6'd4;
        C_BNE:   op = 6'd5;
        C_LW:    op = 6'd35;
        C_SW:    op = 6'd43;
        C_IMM:   op = {3'b001, 3'($urandom_range(0, 7))};
        default: begin
          op = 6'($urandom_range(16, 63));
          if (op == 6'd35 || op == 6'd43) op = 6'd63;
        end
      endcase
      ins = {op, 20'($urandom), fn};
      run($sformatf("rnd%0d", n), ins, 1'($urandom_range(0, 1)), rdy, 1'b1, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the maximum MEM-state wait cycles before trap.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port instruction, input, 32, the instruction register output from iFetch, valid from the ID state onward.
REQ-005 SHALL have port mem_ready, input, 1, the data RAM/I-O completion handshake.
REQ-006 SHALL have port zero, input, 1, the executer compare result, sampled in EX.
REQ-007 SHALL have ports pc_write and ir_write, each output, 1, the PC and IR load enables.
REQ-008 SHALL have ports RegWrite, Jal, MemtoReg and RegDst, each output, 1, the controls to the decoder/register file.
REQ-009 SHALL have ports mem_req, mem_read and mem_write, each output, 1, the data-memory request and its direction.
REQ-010 SHALL have ports ALUSrc, Branch and Jump, each output, 1, the executer/PC source selects.
REQ-011 SHALL have ports state, output, 3; retire, output, 1; retired_cnt, output, 32; and trap, output, 1.

Function
REQ-012 SHALL implement the states IF=0, ID=1, EX=2, MEM=3, WB=4 and TRAP=5; codes 6 and 7 SHALL go to TRAP.
REQ-013 In IF, SHALL assert ir_write and pc_write (PC+4), then go to ID.
REQ-014 In ID, SHALL latch instruction[31:26] and [5:0] internally; all later states SHALL decode from the latched copies only.
REQ-015 From ID, opcode 000010 (j) SHALL assert Jump and pc_write, pulse retire, and go to IF.
REQ-016 From ID, opcode 000011 (jal) SHALL go to WB.
REQ-017 From ID, R-type with funct 001000 (jr) SHALL assert Jump and pc_write, pulse retire, and go to IF.
REQ-018 From ID, an unsupported opcode SHALL go to TRAP.
REQ-019 From ID, all other instructions SHALL go to EX.
REQ-020 Supported opcodes SHALL be 000000, 100011, 101011, 000100, 000101, 000010, 000011 and 001xxx.
REQ-021 In EX, ALUSrc SHALL be 1 for lw, sw and 001xxx, and 0 otherwise.
REQ-022 In EX, beq/bne SHALL assert Branch, assert pc_write only when zero==1 for beq or zero==0 for bne, pulse retire, and go to IF.
REQ-023 From EX, lw/sw SHALL go to MEM; R-type and 001xxx SHALL go to WB.
REQ-024 In MEM, SHALL hold mem_req with mem_read (lw) or mem_write (sw) until mem_ready is sampled high.
REQ-025 On mem_ready, sw SHALL pulse retire and go to IF; lw SHALL go to WB.
REQ-026 A wait counter SHALL count MEM cycles; reaching MEM_TIMEOUT without mem_ready SHALL go to TRAP with the counter cleared.
REQ-027 If mem_ready is high on the first MEM cycle, exit SHALL occur after exactly one MEM cycle.
REQ-028 WB SHALL last exactly one cycle with RegWrite=1.
REQ-029 In WB, MemtoReg SHALL be 1 only for lw, RegDst SHALL be 1 only for R-type, and Jal SHALL be 1 only for jal, with pc_write and Jump also asserted for jal.
REQ-030 WB SHALL pulse retire and go to IF.
REQ-031 Every control output SHALL be 0 in any state/instruction combination not listed above.
REQ-032 TRAP SHALL be absorbing until reset, with trap=1 and all other controls 0.
REQ-033 retire SHALL be a single-cycle pulse, at most once per instruction.
REQ-034 retired_cnt SHALL increment on each retire and wrap from FFFF_FFFF to 0.
REQ-035 Latency SHALL be: j/jr 2 cycles, branch 3, ALU 4, sw 3+waits, lw 4+waits, jal 3.

Reset
REQ-036 While rst=0, the sequencer SHALL be in state IF with all outputs 0, retired_cnt=0, trap=0, and latched fields and wait counter 0.
REQ-037 Reset asserted mid-MEM SHALL drop mem_req asynchronously, and no retire SHALL occur for the aborted instruction.
REQ-038 On the first clk edge after rst rises, the sequencer SHALL be in IF and assert ir_write and pc_write.

Structure
REQ-039 The state encodings and opcode/funct constants SHALL reside in the shared CPU package, reused by the controller and executer.
REQ-040 The sequencer SHALL contain one sub-module, mem_wait_timer, comprising the MEM wait counter and timeout compare.

Verification
REQ-041 R-type add (0x012A4020), rst released: the bench SHALL see state 0,1,2,4, RegWrite=1 with RegDst=1 in cycle 4, and retired_cnt=1.
REQ-042 lw (0x8D280004) with mem_ready delayed 3 cycles: the bench SHALL see 3 MEM cycles, WB with MemtoReg=1, and retire on cycle 7.
REQ-043 beq (0x11090003) with zero=1, then with zero=0: the bench SHALL see pc_write=1 then 0 in EX, and retire both times.
REQ-044 jal (0x0C000010): the bench SHALL see WB with Jal=1, RegWrite=1 and pc_write=1, and a 3-cycle latency.
REQ-045 sw with mem_ready held low: the bench SHALL see TRAP after 15 MEM cycles, trap=1 held, and no retire.
REQ-046 retired_cnt preset by forcing to FFFF_FFFF, then a j executed: the bench SHALL see retired_cnt=0.
